// File: rtl/mips_pkg.sv
// Shared MIPS core types: fetch FSM states, IF/ID payload, reset constants.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ifid_payload_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/gnt bus between the fetch stage and instruction memory.
interface fetch_stage_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: payload plus valid, with load / clear / hold.
module ifid_reg
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clr_i,
  input  ifid_payload_t payload_i,
  output logic          valid_o,
  output ifid_payload_t payload_o
);

  logic          valid_q;
  ifid_payload_t payload_q;

  // Load beats clear: a loaded instruction is younger than whatever is flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '{instr: NOP_INSTR, pc: '0, pc4: '0};
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= payload_i;
    end else if (clr_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/gnt, skid for stalled grants, IF/ID.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_stage_if.master       imem,
  output logic [XLEN-1:0]     pc_o,
  input  logic [XLEN-1:0]     next_pc_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                ifid_valid_o,
  output logic [XLEN-1:0]     ifid_instr_o,
  output logic [XLEN-1:0]     ifid_pc_o,
  output logic [XLEN-1:0]     ifid_pc4_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_q, skid_d;
  logic            req_q, req_d;

  logic            ifid_load_c;
  logic            ifid_clr_c;
  logic [XLEN-1:0] ifid_instr_c;
  ifid_payload_t   ifid_in_c;
  ifid_payload_t   ifid_out_c;

  // Next-state and IF/ID control; redirect > load > flush > stall in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    ifid_load_c  = 1'b0;
    ifid_clr_c   = 1'b0;
    ifid_instr_c = imem.imem_rdata;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect_i) begin
          pc_d       = word_align(redirect_pc_i);
          ifid_clr_c = 1'b1;
        end else begin
          ifid_clr_c = flush_i;
        end
      end
      FETCH: begin
        if (redirect_i) begin
          pc_d       = word_align(redirect_pc_i);
          ifid_clr_c = 1'b1;
        end else if (imem.imem_gnt) begin
          if (!stall_i) begin
            ifid_load_c = 1'b1;
            pc_d        = next_pc_i;
          end else begin
            skid_d     = imem.imem_rdata;
            state_d    = HOLD;
            ifid_clr_c = flush_i;
          end
        end else begin
          // A missing grant without stall leaves a bubble behind.
          ifid_clr_c = !stall_i || flush_i;
        end
      end
      HOLD: begin
        ifid_instr_c = skid_q;
        if (redirect_i) begin
          pc_d       = word_align(redirect_pc_i);
          ifid_clr_c = 1'b1;
          state_d    = FETCH;
        end else if (!stall_i) begin
          ifid_load_c = 1'b1;
          pc_d        = next_pc_i;
          state_d     = FETCH;
        end else begin
          ifid_clr_c = flush_i;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    req_d = (state_d == FETCH);
  end

  // FSM, PC, skid and request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
    end
  end

  assign ifid_in_c = '{instr: ifid_instr_c, pc: pc_q, pc4: next_pc_i};

  ifid_reg u_ifid_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (ifid_load_c),
    .clr_i     (ifid_clr_c),
    .payload_i (ifid_in_c),
    .valid_o   (ifid_valid_o),
    .payload_o (ifid_out_c)
  );

  assign pc_o           = pc_q;
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = word_align(pc_q);
  assign ifid_instr_o   = ifid_out_c.instr;
  assign ifid_pc_o      = ifid_out_c.pc;
  assign ifid_pc4_o     = ifid_out_c.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus.master),
    .pc_o          (pc),
    .next_pc_i     (next_pc),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .ifid_valid_o  (ifid_valid),
    .ifid_instr_o  (ifid_instr),
    .ifid_pc_o     (ifid_pc),
    .ifid_pc4_o    (ifid_pc4)
  );

  always #5 clk = ~clk;

  // External PC adder and instruction memory (word = ~address).
  assign next_pc             = pc + 32'd4;
  assign imem_bus.imem_rdata = ~imem_bus.imem_addr;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    bit          chk_payload;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: where the fetch pointer is, whether it is booting,
  // whether a granted word is parked, and what IF/ID should hold.
  logic [31:0] m_pc;
  bit          m_booting, m_parked, m_fresh;
  logic [31:0] m_parked_word;
  logic        m_v;
  logic [31:0] m_instr, m_ipc, m_ipc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~{a[31:2], 2'b00};
  endfunction

  function automatic void deliver(input logic [31:0] w);
    m_v     = 1'b1;
    m_instr = w;
    m_ipc   = m_pc;
    m_ipc4  = m_pc + 32'd4;
    m_pc    = m_pc + 32'd4;
  endfunction

  function automatic void model_step(input bit r, input bit g, input bit st,
                                     input bit fl, input bit rd, input logic [31:0] rp);
    if (!r) begin
      m_pc = 32'h0; m_booting = 1; m_parked = 0; m_fresh = 1;
      m_v = 0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
      return;
    end
    m_fresh = 0;
    if (rd) begin
      m_pc = rp & ~32'd3; m_v = 0; m_booting = 0; m_parked = 0;
    end else if (m_booting) begin
      m_booting = 0;
      if (fl) m_v = 0;
    end else if (m_parked) begin
      if (!st) begin deliver(m_parked_word); m_parked = 0; end
      else if (fl) m_v = 0;
    end else begin
      if (g && !st) deliver(mem_word(m_pc));
      else if (g && st) begin
        m_parked = 1; m_parked_word = mem_word(m_pc);
        if (fl) m_v = 0;
      end else if (!st || fl) m_v = 0;
    end
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.req = !m_booting && !m_parked;
    e.pc = m_pc; e.v = m_v; e.instr = m_instr; e.ipc = m_ipc; e.ipc4 = m_ipc4;
    e.chk_payload = m_fresh || m_v;
    return e;
  endfunction

  // One cycle: record expected outputs for this cycle, drive inputs, advance model.
  task automatic cyc(input bit r, input bit g, input bit st, input bit fl,
                     input bit rd, input logic [31:0] rp);
    exp_q.push_back(cur_exp());
    rst_n = r; imem_bus.imem_gnt = g; stall = st; flush = fl;
    redirect = rd; redirect_pc = rp;
    model_step(r, g, st, fl, rd, rp);
    @(posedge clk); #1;
  endtask

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endfunction

  // Monitor: mid-cycle, pop the expectation for this cycle and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check("imem_req", 32'(imem_bus.imem_req), 32'(e.req));
        check("pc", pc, e.pc);
        check("imem_addr", imem_bus.imem_addr, {e.pc[31:2], 2'b00});
        check("ifid_valid", 32'(ifid_valid), 32'(e.v));
        if (e.chk_payload) begin
          check("ifid_instr", ifid_instr, e.instr);
          check("ifid_pc", ifid_pc, e.ipc);
          check("ifid_pc4", ifid_pc4, e.ipc4);
        end
      end
    end
  end

  initial begin
    rst_n = 0; imem_bus.imem_gnt = 0; stall = 0; flush = 0;
    redirect = 0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_step(0, 0, 0, 0, 0, 32'h0);

    // Boot, then fetch 0 and 4.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Two wait states at pc=8, then 8 is fetched once.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Grant during stall at 0xC, three stall cycles, release.
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Redirect at 0x14 with unaligned target 0x43.
    cyc(1, 1, 0, 0, 1, 32'h43);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Park a word, then redirect while held in stall.
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 32'h200);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Flush alone, flush with a load, flush while parked.
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Address wrap past 0xFFFF_FFFC.
    cyc(1, 1, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    // Run up to 0x30, single-edge reset mid-stream.
    cyc(1, 1, 0, 0, 1, 32'h28);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bit          r, g, st, fl, rd;
      logic [31:0] rp;
      r  = ($urandom_range(0, 199) != 0);
      g  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                         : ($urandom & 32'h0000_3FFF);
      cyc(r, g, st, fl, rd, rp);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined MIPS core. It holds the program counter, issues word fetches to instruction memory over a req/gnt handshake, and takes the incremented PC back from the external PC adder. It also applies hazard-unit stall/flush and branch/jump redirects, and drives the IF/ID pipeline register consumed by the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- pc  out  32  current fetch PC; drives the PC adder input.
- next_pc  in  32  PC adder result (pc + 4).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, {pc[31:2], 2'b00}.
- imem_gnt  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  32  instruction word; valid when imem_req && imem_gnt.
- stall  in  1  hazard unit: hold IF/ID and PC.
- flush  in  1  hazard unit: invalidate IF/ID.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  target address; bits [1:0] are ignored (stored as 00).
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  32  PC of ifid_instr.
- ifid_pc4  out  32  next_pc captured with ifid_instr.

## Operation
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=BOOT, ifid_valid=0, ifid_instr=32'h0000_0000 (NOP), ifid_pc=0, ifid_pc4=0, skid=0, imem_req=0.
- Precedence in every state: redirect > IF/ID load > flush > stall.
- BOOT: imem_req=0. Next state is FETCH unconditionally, unless reset is held.
- FETCH: imem_req=1, imem_addr=pc.
  - redirect: pc<=redirect_pc&~3, ifid_valid<=0, any grant this cycle is discarded; stay in FETCH.
  - gnt && !stall: IF/ID<={1, imem_rdata, pc, next_pc}; pc<=next_pc.
  - gnt && stall: skid<=imem_rdata; pc held; IF/ID held (ifid_valid<=0 if flush); go to HOLD.
  - !gnt && !stall: ifid_valid<=0 (bubble); pc held.
  - !gnt && stall: IF/ID held (ifid_valid<=0 if flush).
- HOLD: imem_req=0. The instruction is parked in skid; pc still addresses it.
  - redirect: pc<=redirect_pc&~3, ifid_valid<=0, skid discarded; go to FETCH.
  - !stall: IF/ID<={1, skid, pc, next_pc}; pc<=next_pc; go to FETCH.
  - stall: stay; flush clears ifid_valid.
- flush without redirect: clears ifid_valid only. A load in the same cycle wins, because the loaded instruction is younger.
- Address arithmetic is 32-bit and done externally. 0xFFFF_FFFC wraps to 0 with no detection.
- Only ifid_valid is cleared on a bubble, flush or redirect; the ifid_instr/pc/pc4 payload is don't-care when ifid_valid=0.

## Timing
- Fetch-to-IF/ID latency: one edge after the granted cycle, when not stalled.
- Throughput: one instruction per cycle while gnt=1 and stall=0.
- Redirect: the target appears on imem_addr in the cycle after redirect is sampled. The first target instruction reaches IF/ID at the earliest two edges after redirect.
- Stall: IF/ID and pc are frozen on every edge where stall=1. A fetch granted during stall is never re-requested.
- Reset mid-operation overrides all inputs on that edge. The outstanding fetch and skid are dropped.
- imem_req is a registered function of state only, so it is glitch-free and independent of gnt.

## Structure
- Shared package mips_pkg holds:
  - the fetch state enum (BOOT, FETCH, HOLD),
  - NOP_INSTR = 32'h0000_0000,
  - the default RESET_PC.
- Sub-module ifid_reg: the IF/ID payload plus valid, with load/flush/hold controls driven by the fetch FSM. The decode stage reuses the same pattern.
- The PC adder stays external, connected via pc and next_pc.

## Test plan
- Reset release, gnt=1 constant, memory returns word = address: cycle 0 BOOT with req=0. Then imem_addr goes 0,4,8. IF/ID shows (instr 0, pc 0, pc4 4) on the edge after the first grant, then advances one per cycle.
- Wait states (gnt low for 2 cycles at pc=8): ifid_valid=0 for those 2 cycles, pc held at 8, then 8 is loaded with no duplicate.
- Stall during a grant at pc=0xC: FSM enters HOLD and imem_req drops. IF/ID holds 0x8 for 3 stall cycles. On release IF/ID=0xC and the next address is 0x10, with no re-fetch of 0xC.
- Redirect to 0x40 while gnt=1 at pc=0x14: 0x14 is discarded and ifid_valid=0. imem_addr=0x40 next cycle; redirect_pc=0x43 also yields 0x40.
- Redirect while in HOLD with stall=1: skid is dropped, FETCH is entered at the target, and ifid_valid=0.
- rst_n low for one edge mid-stream at pc=0x30: next cycle pc=RESET_PC, state BOOT, all outputs at reset values.
